// File: rtl/dpu_multimode_seq.sv
// DRRA cell DPU: two-stage saturating fixed-point datapath whose operation is
// chosen per cycle by a programmable multi-state sequencer.
module dpu_multimode_seq #(
  parameter int WIDTH       = 16,
  parameter int NUM_STATES  = 4,
  parameter int DELAY_WIDTH = 4,
  parameter int MODE_WIDTH  = 6,
  parameter int IMM_WIDTH   = 8,
  parameter int FRAC_BITS   = 0,
  parameter int SATURATE    = 1,
  parameter int INSTR_WIDTH = 27
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          instr_en,
  input  logic [INSTR_WIDTH-1:0]        instr,
  input  logic                          activate,
  input  logic [WIDTH-1:0]              in0,
  input  logic [WIDTH-1:0]              in1,
  output logic [WIDTH-1:0]              out0,
  output logic                          out_valid,
  output logic [$clog2(NUM_STATES)-1:0] state_o,
  output logic                          running_o,
  output logic                          sat_flag
);
  localparam int SW      = $clog2(NUM_STATES);
  localparam int FW      = 2*WIDTH + 1;
  localparam int OP_LSB  = INSTR_WIDTH - 3;
  localparam int MODE_HI = OP_LSB - 1 - SW;
  localparam int IMM_HI  = MODE_HI - MODE_WIDTH;
  localparam logic [SW-1:0] LAST = SW'(NUM_STATES - 1);
  localparam logic signed [FW-1:0] SMAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] SMIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_FSM = 3'd2,
    OP_DPU = 3'd3
  } opcode_e;

  typedef enum logic [MODE_WIDTH-1:0] {
    M_IDLE = MODE_WIDTH'(0),
    M_ADD  = MODE_WIDTH'(1),
    M_SUB  = MODE_WIDTH'(2),
    M_ADDI = MODE_WIDTH'(3),
    M_MUL  = MODE_WIDTH'(7),
    M_MULI = MODE_WIDTH'(8),
    M_MAC  = MODE_WIDTH'(10),
    M_MAX  = MODE_WIDTH'(11),
    M_MIN  = MODE_WIDTH'(12)
  } mode_e;

  logic [SW-1:0]          state_q, state_d, nxt_state;
  logic                   running_q, running_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [DELAY_WIDTH-1:0] delay_q [NUM_STATES];
  logic [DELAY_WIDTH-1:0] delay_d [NUM_STATES];
  logic [DELAY_WIDTH-1:0] fsm_delay [NUM_STATES];
  logic [MODE_WIDTH-1:0]  mode_q [NUM_STATES];
  logic [MODE_WIDTH-1:0]  mode_d [NUM_STATES];
  logic [IMM_WIDTH-1:0]   imm_q [NUM_STATES];
  logic [IMM_WIDTH-1:0]   imm_d [NUM_STATES];
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, acc_q, acc_d, out0_q, out0_d;
  logic                   out_valid_q, out_valid_d, sat_q, sat_d;
  logic [2:0]             opcode;
  logic [SW-1:0]          wr_slot;
  logic                   unused_instr;

  logic [MODE_WIDTH-1:0]  cur_mode;
  logic [IMM_WIDTH-1:0]   cur_imm;
  logic signed [FW-1:0]   a_f, b_f, i_f, acc_f, full;
  logic signed [2*WIDTH-1:0] p_ab, p_ai, sh_ab, sh_ai;
  logic                   mode_ok, over, under, sat_ev;
  logic [WIDTH-1:0]       res;

  assign unused_instr = ^instr;

  // The last state has no delay field; its entry stays zero and is never loaded.
  for (genvar g = 0; g < NUM_STATES; g++) begin : g_dly
    if (g < NUM_STATES - 1) begin : g_fld
      assign fsm_delay[g] = instr[OP_LSB-1-g*DELAY_WIDTH -: DELAY_WIDTH];
    end else begin : g_last
      assign fsm_delay[g] = '0;
    end
  end

  always_comb begin
    opcode  = instr[INSTR_WIDTH-1 -: 3];
    wr_slot = instr[OP_LSB-1 -: SW];
    mode_d  = mode_q;
    imm_d   = imm_q;
    delay_d = delay_q;
    if (instr_en && opcode == OP_DPU) begin
      mode_d[wr_slot] = instr[MODE_HI -: MODE_WIDTH];
      imm_d[wr_slot]  = instr[IMM_HI -: IMM_WIDTH];
    end else if (instr_en && opcode == OP_FSM) begin
      delay_d = fsm_delay;
    end
  end

  // Activate loads delay_d[0] so an FSM write in the same cycle is honoured.
  always_comb begin
    nxt_state = state_q + SW'(1);
    state_d   = state_q;
    running_d = running_q;
    cnt_d     = cnt_q;
    if (activate) begin
      state_d   = '0;
      running_d = 1'b1;
      cnt_d     = delay_d[0];
    end else if (running_q && state_q != LAST) begin
      if (cnt_q == '0) begin
        state_d = nxt_state;
        cnt_d   = delay_q[nxt_state];
      end else begin
        cnt_d = cnt_q - DELAY_WIDTH'(1);
      end
    end
  end

  always_comb begin
    a_d      = in0;
    b_d      = in1;
    cur_mode = mode_q[state_q];
    cur_imm  = imm_q[state_q];
    a_f      = {{(FW-WIDTH){a_q[WIDTH-1]}}, a_q};
    b_f      = {{(FW-WIDTH){b_q[WIDTH-1]}}, b_q};
    i_f      = {{(FW-IMM_WIDTH){cur_imm[IMM_WIDTH-1]}}, cur_imm};
    acc_f    = {{(FW-WIDTH){acc_q[WIDTH-1]}}, acc_q};
    p_ab     = a_f[2*WIDTH-1:0] * b_f[2*WIDTH-1:0];
    p_ai     = a_f[2*WIDTH-1:0] * i_f[2*WIDTH-1:0];
    sh_ab    = p_ab >>> FRAC_BITS;
    sh_ai    = p_ai >>> FRAC_BITS;
    mode_ok  = 1'b1;
    full     = '0;
    case (cur_mode)
      M_ADD:   full = a_f + b_f;
      M_SUB:   full = a_f - b_f;
      M_ADDI:  full = a_f + i_f;
      M_MUL:   full = {sh_ab[2*WIDTH-1], sh_ab};
      M_MULI:  full = {sh_ai[2*WIDTH-1], sh_ai};
      M_MAC:   full = acc_f + {sh_ab[2*WIDTH-1], sh_ab};
      M_MAX:   full = (a_f > b_f) ? a_f : b_f;
      M_MIN:   full = (a_f < b_f) ? a_f : b_f;
      default: mode_ok = 1'b0;
    endcase
    over   = full > SMAX;
    under  = full < SMIN;
    sat_ev = (SATURATE != 0) && (over || under);
    res    = full[WIDTH-1:0];
    if (sat_ev) res = over ? SMAX[WIDTH-1:0] : SMIN[WIDTH-1:0];

    out_valid_d = running_q && mode_ok;
    out0_d      = out_valid_d ? res : '0;
    acc_d       = acc_q;
    if (activate)                           acc_d = '0;
    else if (out_valid_d && cur_mode == M_MAC) acc_d = res;
    sat_d = activate ? 1'b0 : (sat_q | (out_valid_d & sat_ev));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= '0;
      running_q   <= 1'b0;
      cnt_q       <= '0;
      delay_q     <= '{default: '0};
      mode_q      <= '{default: '0};
      imm_q       <= '{default: '0};
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out0_q      <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      cnt_q       <= cnt_d;
      delay_q     <= delay_d;
      mode_q      <= mode_d;
      imm_q       <= imm_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out0_q      <= out0_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign out0      = out0_q;
  assign out_valid = out_valid_q;
  assign state_o   = state_q;
  assign running_o = running_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_dpu_multimode_seq.sv
// Directed bench for dpu_multimode_seq: default, wrapping and fractional instances
// share stimulus; expected outputs are queued with their due cycle.
module tb_dpu_multimode_seq;
  logic        clk = 1'b0;
  logic        rst, instr_en, activate;
  logic [26:0] instr;
  logic [15:0] in0, in1;

  logic [15:0] out0_m, out0_w, out0_f;
  logic        vld_m, vld_w, vld_f, run_m, run_w, run_f, sat_m, sat_w, sat_f;
  logic [1:0]  st_m, st_w, st_f;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    int          dut;
    logic [15:0] val;
    logic        vld;
    string       tag;
  } exp_t;
  exp_t sbq[$];

  int   exp_st[9] = '{0, 0, 0, 1, 2, 2, 3, 3, 3};
  int   exp_ms[6] = '{5, 5, 20, 0, 10, 10};
  logic exp_mv[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  dpu_multimode_seq u_dut (
    .clk(clk), .rst(rst), .instr_en(instr_en), .instr(instr), .activate(activate),
    .in0(in0), .in1(in1), .out0(out0_m), .out_valid(vld_m), .state_o(st_m),
    .running_o(run_m), .sat_flag(sat_m)
  );

  dpu_multimode_seq #(.SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .instr_en(instr_en), .instr(instr), .activate(activate),
    .in0(in0), .in1(in1), .out0(out0_w), .out_valid(vld_w), .state_o(st_w),
    .running_o(run_w), .sat_flag(sat_w)
  );

  dpu_multimode_seq #(.FRAC_BITS(8)) u_frac (
    .clk(clk), .rst(rst), .instr_en(instr_en), .instr(instr), .activate(activate),
    .in0(in0), .in1(in1), .out0(out0_f), .out_valid(vld_f), .state_o(st_f),
    .running_o(run_f), .sat_flag(sat_f)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [26:0] dpu_i(input logic [1:0] slot, input logic [5:0] mode,
                                        input logic [7:0] imm);
    return {3'd3, slot, mode, imm, 8'd0};
  endfunction

  function automatic logic [26:0] fsm_i(input logic [3:0] d0, input logic [3:0] d1,
                                        input logic [3:0] d2);
    return {3'd2, d0, d1, d2, 12'd0};
  endfunction

  function automatic logic [15:0] obs_out(input int d);
    case (d)
      0:       return out0_m;
      1:       return out0_w;
      default: return out0_f;
    endcase
  endfunction

  function automatic logic obs_vld(input int d);
    case (d)
      0:       return vld_m;
      1:       return vld_w;
      default: return vld_f;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int dut, input logic [15:0] val, input logic vld, input string tag);
    exp_t e;
    e.due = cyc + 2;
    e.dut = dut;
    e.val = val;
    e.vld = vld;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check({e.tag, "_out"}, {16'd0, obs_out(e.dut)}, {16'd0, e.val});
      check({e.tag, "_vld"}, {31'd0, obs_vld(e.dut)}, {31'd0, e.vld});
    end
  endtask

  task automatic wr(input logic [26:0] ins);
    instr_en = 1'b1;
    instr    = ins;
    tick();
    instr_en = 1'b0;
    instr    = '0;
  endtask

  initial begin
    rst = 1'b1; instr_en = 1'b0; activate = 1'b0; instr = '0; in0 = '0; in1 = '0;
    tick();
    tick();
    check("rst_out0", {16'd0, out0_m}, 32'd0);
    check("rst_vld", {31'd0, vld_m}, 32'd0);
    check("rst_state", {30'd0, st_m}, 32'd0);
    check("rst_run", {31'd0, run_m}, 32'd0);
    check("rst_sat", {31'd0, sat_m}, 32'd0);
    rst = 1'b0;

    // Sequencer timing with delays 2,0,1 and a restart
    wr(fsm_i(4'd2, 4'd0, 4'd1));
    activate = 1'b1; tick(); activate = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("state_c%0d", i + 1), {30'd0, st_m}, exp_st[i]);
      if (i == 4) check("run_mid", {31'd0, run_m}, 32'd1);
      if (i == 4) check("idle_mode_vld", {31'd0, vld_m}, 32'd0);
      tick();
    end
    activate = 1'b1; tick(); activate = 1'b0;
    check("restart_state", {30'd0, st_m}, 32'd0);
    check("restart_run", {31'd0, run_m}, 32'd1);

    // ADD with saturation and wrap
    wr(fsm_i(4'd15, 4'd15, 4'd15));
    wr(dpu_i(2'd0, 6'd1, 8'd0));
    in0 = 16'd30000; in1 = 16'd10000;
    push(0, 16'h7FFF, 1'b1, "add_sat");
    push(1, 16'h9C40, 1'b1, "add_wrap");
    push(2, 16'h7FFF, 1'b1, "add_sat_f");
    activate = 1'b1; tick(); activate = 1'b0;
    in0 = 16'd100; in1 = 16'hFED4;
    push(0, 16'hFF38, 1'b1, "add_neg");
    push(1, 16'hFF38, 1'b1, "add_neg_w");
    tick();
    check("add_satflag", {31'd0, sat_m}, 32'd1);
    check("wrap_satflag", {31'd0, sat_w}, 32'd0);
    tick();
    check("sat_sticky", {31'd0, sat_m}, 32'd1);

    // Reset in the middle of a run
    in0 = 16'd1; in1 = 16'd2; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out0", {16'd0, out0_m}, 32'd0);
    check("mrst_vld", {31'd0, vld_m}, 32'd0);
    check("mrst_state", {30'd0, st_m}, 32'd0);
    check("mrst_run", {31'd0, run_m}, 32'd0);
    check("mrst_sat", {31'd0, sat_m}, 32'd0);
    wr(fsm_i(4'd15, 4'd15, 4'd15));
    wr(dpu_i(2'd0, 6'd1, 8'd0));
    in0 = 16'd1000; in1 = 16'hF448;
    push(0, 16'hF830, 1'b1, "add_after_rst");
    activate = 1'b1; tick(); activate = 1'b0;
    in0 = 16'h8000; in1 = 16'hFFFF;
    push(0, 16'h8000, 1'b1, "add_min_sat");
    push(1, 16'h7FFF, 1'b1, "add_min_wrap");
    tick();
    check("sat_clear_after_rst", {31'd0, sat_m}, 32'd0);
    tick();
    check("sat_min", {31'd0, sat_m}, 32'd1);

    // MUL / MULI, fractional shift, slot rewrite while running
    in0 = 16'd0; in1 = 16'd0;
    wr(dpu_i(2'd0, 6'd7, 8'd0));
    in0 = 16'hFF38; in1 = 16'd300;
    push(0, 16'h8000, 1'b1, "mul_sat");
    push(1, 16'h15A0, 1'b1, "mul_wrap");
    push(2, 16'hFF15, 1'b1, "mul_frac_neg");
    activate = 1'b1; tick(); activate = 1'b0;
    check("sat_clr_on_act", {31'd0, sat_m}, 32'd0);
    in0 = 16'd512; in1 = 16'd768;
    push(0, 16'h7FFF, 1'b1, "mul_big_sat");
    push(1, 16'h0000, 1'b1, "mul_big_wrap");
    push(2, 16'h0600, 1'b1, "mul_frac");
    tick();
    check("mul_satflag", {31'd0, sat_m}, 32'd1);
    in0 = 16'd1000; in1 = 16'd7;
    push(0, 16'hF448, 1'b1, "muli");
    push(2, 16'hFFF4, 1'b1, "muli_frac");
    wr(dpu_i(2'd0, 6'd8, 8'hFD));
    in0 = 16'd0; in1 = 16'd0;
    tick();

    // MAC accumulation and restart
    wr(dpu_i(2'd0, 6'd10, 8'd0));
    in0 = 16'd3; in1 = 16'd4;
    push(0, 16'd12, 1'b1, "mac1");
    push(2, 16'd0, 1'b1, "mac_frac");
    activate = 1'b1; tick(); activate = 1'b0;
    push(0, 16'd24, 1'b1, "mac2");
    tick();
    push(0, 16'd36, 1'b1, "mac3");
    tick();
    push(0, 16'd48, 1'b1, "mac4");
    tick();
    in0 = 16'd0; in1 = 16'd0;
    tick();
    tick();
    in0 = 16'd3; in1 = 16'd4;
    push(0, 16'd12, 1'b1, "mac_restart");
    activate = 1'b1; tick(); activate = 1'b0;
    push(0, 16'd24, 1'b1, "mac_restart2");
    tick();
    in0 = 16'd0; in1 = 16'd0;
    tick();

    // Mode switching across states: ADDI, MAX, undefined, MIN
    wr(fsm_i(4'd1, 4'd0, 4'd0));
    wr(dpu_i(2'd0, 6'd3, 8'hFB));
    wr(dpu_i(2'd1, 6'd11, 8'd0));
    wr(dpu_i(2'd2, 6'd63, 8'd0));
    wr(dpu_i(2'd3, 6'd12, 8'd0));
    in0 = 16'd10; in1 = 16'd20;
    for (int i = 0; i < 6; i++) begin
      push(0, exp_ms[i][15:0], exp_mv[i], $sformatf("mode_sw%0d", i));
      if (i == 0) activate = 1'b1;
      tick();
      activate = 1'b0;
    end
    tick();
    tick();
    check("last_state_hold", {30'd0, st_m}, 32'd3);

    // Activate together with a DPU write to slot 0 (SUB)
    push(0, 16'hFFF6, 1'b1, "act_cfg_same");
    activate = 1'b1;
    wr(dpu_i(2'd0, 6'd2, 8'd0));
    activate = 1'b0;
    tick();
    tick();

    check("sb_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
